// File: rtl/sobel_frame_sched.sv
// Frame scheduler in front of a Sobel pipeline: feeds one frame, appends
// padding lines, then waits for the result stream (with a watchdog).
module sobel_frame_sched #(
  parameter int         IMG_W       = 640,
  parameter int         IMG_H       = 480,
  parameter int         FLUSH_LINES = 2,
  parameter logic [7:0] FLUSH_VAL   = 8'h00,
  parameter int         EXP_OUT     = IMG_W * IMG_H,
  parameter int         TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        start,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  input  logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [23:0] res_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [23:0] FRAME_PIX = 24'(IMG_W * IMG_H);
  localparam logic [23:0] FLUSH_PIX = 24'(FLUSH_LINES * IMG_W);
  localparam logic [23:0] EXP_C     = 24'(EXP_OUT);
  localparam logic [23:0] TO_C      = 24'(TIMEOUT);

  state_t      state, state_nx;
  logic [23:0] in_cnt, drain_cnt, in_tgt;
  logic        in_beat, res_fire, res_full;
  logic        in_last, to_hit, res_live;

  assign in_beat  = snk_valid & snk_ready;
  assign res_fire = res_valid & res_ready;
  assign res_full = (res_cnt == EXP_C);
  assign in_tgt   = (state == S_FEED) ? FRAME_PIX : FLUSH_PIX;
  assign in_last  = in_beat && (in_cnt + 24'd1 == in_tgt);
  assign to_hit   = !res_fire && (drain_cnt + 24'd1 == TO_C);
  assign res_live = (state == S_FEED) || (state == S_FLUSH) ||
                    (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst_p) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_FEED;
      S_FEED: begin
        if (res_full)     state_nx = S_DONE;
        else if (in_last) state_nx = (FLUSH_PIX == 24'd0) ? S_DRAIN
                                                           : S_FLUSH;
      end
      S_FLUSH: begin
        if (res_full)     state_nx = S_DONE;
        else if (in_last) state_nx = S_DRAIN;
      end
      S_DRAIN: if (res_full || to_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    src_ready  = 1'b0;
    snk_valid  = 1'b0;
    snk_data   = 8'h00;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_FEED: begin
        src_ready = snk_ready;
        snk_valid = src_valid;
        snk_data  = src_data;
      end
      S_FLUSH: begin
        snk_valid = 1'b1;
        snk_data  = FLUSH_VAL;
      end
      S_DRAIN: ;
      S_DONE:  frame_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      in_cnt      <= '0;
      res_cnt     <= '0;
      drain_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        in_cnt      <= '0;
        res_cnt     <= '0;
        timeout_err <= 1'b0;
      end else begin
        if ((state == S_FEED || state == S_FLUSH) && in_beat)
          in_cnt <= in_last ? 24'd0 : in_cnt + 24'd1;
        if (res_live && res_fire && !res_full)
          res_cnt <= res_cnt + 24'd1;
      end
      // Cleared outside DRAIN so every DRAIN entry starts from zero.
      if (state != S_DRAIN || res_fire) drain_cnt <= '0;
      else                              drain_cnt <= drain_cnt + 24'd1;
      if (state == S_DRAIN && !res_full && to_hit)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Bench for sobel_frame_sched: table of frame scenarios with a pixel
// scoreboard, plus hand sequences for reset corner cases.
module tb_sobel_frame_sched;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int TO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_p, start, start0;
  logic [7:0] src_data;
  logic       src_valid, snk_ready, res_valid, res_ready;

  logic        a_src_ready, a_snk_valid, a_busy, a_done, a_to;
  logic [7:0]  a_snk_data;
  logic [23:0] a_res_cnt;
  logic        b_src_ready, b_snk_valid, b_busy, b_done, b_to;
  logic [7:0]  b_snk_data;
  logic [23:0] b_res_cnt;

  sobel_frame_sched #(
    .IMG_W(W), .IMG_H(H), .FLUSH_LINES(2), .FLUSH_VAL(8'h00),
    .EXP_OUT(NPIX), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_p(rst_p), .start(start),
    .src_data(src_data), .src_valid(src_valid), .src_ready(a_src_ready),
    .snk_data(a_snk_data), .snk_valid(a_snk_valid), .snk_ready(snk_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(a_busy), .frame_done(a_done), .timeout_err(a_to),
    .res_cnt(a_res_cnt)
  );

  sobel_frame_sched #(
    .IMG_W(W), .IMG_H(H), .FLUSH_LINES(0), .FLUSH_VAL(8'h00),
    .EXP_OUT(NPIX), .TIMEOUT(TO)
  ) u_dut0 (
    .clk(clk), .rst_p(rst_p), .start(start0),
    .src_data(src_data), .src_valid(src_valid), .src_ready(b_src_ready),
    .snk_data(b_snk_data), .snk_valid(b_snk_valid), .snk_ready(snk_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(b_busy), .frame_done(b_done), .timeout_err(b_to),
    .res_cnt(b_res_cnt)
  );

  logic        sel0;
  logic        o_src_ready, o_snk_valid, o_busy, o_done, o_to;
  logic [7:0]  o_snk_data;
  logic [23:0] o_res_cnt;

  always_comb begin
    o_src_ready = sel0 ? b_src_ready : a_src_ready;
    o_snk_valid = sel0 ? b_snk_valid : a_snk_valid;
    o_snk_data  = sel0 ? b_snk_data  : a_snk_data;
    o_busy      = sel0 ? b_busy      : a_busy;
    o_done      = sel0 ? b_done      : a_done;
    o_to        = sel0 ? b_to        : a_to;
    o_res_cnt   = sel0 ? b_res_cnt   : a_res_cnt;
  end

  typedef struct {
    string name;
    bit    toggle;
    bit    res_off;
    bit    fl0;
    bit    pulse;
    bit    exp_to;
    int    exp_res;
    int    exp_drain;
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'(8'h31 + 7 * i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int   beats = 0, sent = 0, sidx = 0, cycles = 0, drain = 0;
    int   total, lat;
    bit   fin = 0;
    logic rdy;
    total = NPIX + (v.fl0 ? 0 : 2 * W);
    lat   = total - NPIX;
    sel0  = v.fl0;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(pix(i));
    if (!v.fl0)
      for (int i = 0; i < 2 * W; i++) exp_q.push_back(8'h00);
    src_valid = 1'b0;
    res_valid = 1'b0;
    snk_ready = 1'b0;
    start  = !v.fl0;
    start0 = v.fl0;
    cyc();
    start  = 1'b0;
    start0 = 1'b0;
    chk({v.name, ":busy_start"}, o_busy, 1);
    chk({v.name, ":to_cleared"}, o_to, 0);
    chk({v.name, ":res_cnt_start"}, o_res_cnt, 0);
    while (!fin && cycles < 300) begin
      rdy       = v.toggle ? ((cycles % 2) == 0) : 1'b1;
      snk_ready = rdy;
      src_valid = 1'b1;
      src_data  = pix(sidx);
      res_valid = (beats - lat > sent) && !(v.res_off && beats >= total);
      start     = v.pulse && (cycles == 3);
      #1;
      if (o_done) fin = 1;
      else begin
        chk({v.name, ":busy"}, o_busy, 1);
        if (beats < NPIX)
          chk({v.name, ":src_ready"}, o_src_ready, rdy);
        else if (beats < total) begin
          if (!rdy) begin
            chk({v.name, ":flush_vld"}, o_snk_valid, 1);
            chk({v.name, ":flush_dat"}, o_snk_data, 0);
          end
        end else begin
          drain++;
          chk({v.name, ":drain_vld"}, o_snk_valid, 0);
        end
      end
      if (o_snk_valid && rdy) begin
        if (exp_q.size() == 0) chk({v.name, ":extra_beat"}, 1, 0);
        else chk({v.name, ":pixel"}, o_snk_data, exp_q.pop_front());
        beats++;
      end
      if (o_src_ready && src_valid) sidx++;
      if (res_valid && res_ready) sent++;
      cyc();
      cycles++;
    end
    start     = 1'b0;
    src_valid = 1'b0;
    res_valid = 1'b0;
    #1;
    chk({v.name, ":done_seen"}, fin, 1);
    chk({v.name, ":done_1cyc"}, o_done, 0);
    chk({v.name, ":idle_busy"}, o_busy, 0);
    chk({v.name, ":res_cnt"}, o_res_cnt, v.exp_res);
    chk({v.name, ":q_empty"}, exp_q.size(), 0);
    chk({v.name, ":drain_cyc"}, drain, v.exp_drain);
    for (int i = 0; i < 2; i++) begin
      chk({v.name, ":to_sticky"}, o_to, v.exp_to);
      cyc();
      chk({v.name, ":no_requeue"}, o_busy, 0);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ":busy"}, a_busy, 0);
    chk({nm, ":done"}, a_done, 0);
    chk({nm, ":to"}, a_to, 0);
    chk({nm, ":res_cnt"}, a_res_cnt, 0);
    chk({nm, ":src_ready"}, a_src_ready, 0);
    chk({nm, ":snk_valid"}, a_snk_valid, 0);
    chk({nm, ":snk_data"}, a_snk_data, 0);
  endtask

  initial begin
    vecs[0] = '{"basic",   0, 0, 0, 0, 0, 12,  2};
    vecs[1] = '{"stall",   1, 0, 0, 0, 0, 12,  2};
    vecs[2] = '{"timeout", 0, 1, 0, 0, 1, 11, 16};
    vecs[3] = '{"restart", 0, 0, 0, 1, 0, 12,  2};
    vecs[4] = '{"fl0",     0, 0, 1, 0, 0, 12,  2};
    vecs[5] = '{"timeout2",0, 1, 0, 0, 1, 11, 16};

    rst_p = 1'b1; start = 1'b0; start0 = 1'b0; sel0 = 1'b0;
    src_data = 8'h00; src_valid = 1'b0; snk_ready = 1'b0;
    res_valid = 1'b0; res_ready = 1'b1;
    cyc();
    cyc();
    rst_p = 1'b0;
    #1;
    chk_reset_state("por");

    foreach (vecs[i]) run_frame(vecs[i]);

    sel0  = 1'b0;
    rst_p = 1'b1;
    cyc();
    rst_p = 1'b0;
    #1;
    chk_reset_state("rst_idle");

    start = 1'b1;
    cyc();
    start = 1'b0;
    src_valid = 1'b1; snk_ready = 1'b1; res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_data = pix(i);
      cyc();
    end
    chk("mid:res_cnt_pre", a_res_cnt, 5);
    rst_p = 1'b1; start = 1'b1;
    cyc();
    rst_p = 1'b0; start = 1'b0;
    src_valid = 1'b0; snk_ready = 1'b0; res_valid = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    run_frame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
